// File: rtl/video_pattern_gen_if.sv
// Video output bundle between the pattern generator and its sink.
// master: generator side (drives timing, coordinates and pixels; receives mode/colour).
// slave : sink side.
//   mode        pattern select: 0 bars, 1 gray ramp, 2 grid, 3 solid
//   solid_rgb   {R,G,B} used by mode 3
//   hs/vs/de    sync and active-video strobes
//   de_read     early copy of de for frame-buffer FIFO pops
//   frame_start one-cycle pulse at frame origin
//   active_x/y  pixel coordinates while de
//   rgb_r/g/b   pixel data, zero outside de
interface video_pattern_gen_if #(
    parameter int unsigned CNT_W = 12
) ();
    logic [1:0]       mode;
    logic [23:0]      solid_rgb;
    logic             hs;
    logic             vs;
    logic             de;
    logic             de_read;
    logic             frame_start;
    logic [CNT_W-1:0] active_x;
    logic [CNT_W-1:0] active_y;
    logic [7:0]       rgb_r;
    logic [7:0]       rgb_g;
    logic [7:0]       rgb_b;

    modport master (
        input  mode, solid_rgb,
        output hs, vs, de, de_read, frame_start,
        output active_x, active_y, rgb_r, rgb_g, rgb_b
    );

    modport slave (
        output mode, solid_rgb,
        input  hs, vs, de, de_read, frame_start,
        input  active_x, active_y, rgb_r, rgb_g, rgb_b
    );
endinterface

// File: rtl/video_pattern_gen.sv
// Video timing generator with selectable test pattern.
// Line/frame order is sync, back porch, active, front porch. Every output is
// registered one cycle after the h/v counters that produce it. The pattern
// mode is latched only at the frame origin so a frame is never mixed.
// Ports:
//   clk  pixel clock
//   rst  asynchronous reset, active high
//   vid  video bundle (master side), see video_pattern_gen_if
module video_pattern_gen #(
    parameter int unsigned H_ACTIVE  = 1920,
    parameter int unsigned H_FP      = 88,
    parameter int unsigned H_SYNC    = 44,
    parameter int unsigned H_BP      = 148,
    parameter int unsigned V_ACTIVE  = 1080,
    parameter int unsigned V_FP      = 4,
    parameter int unsigned V_SYNC    = 5,
    parameter int unsigned V_BP      = 36,
    parameter bit          HS_POL    = 1'b1,
    parameter bit          VS_POL    = 1'b1,
    parameter int unsigned CNT_W     = 12,
    parameter int unsigned PREFETCH  = 3,
    parameter int unsigned GRID_STEP = 64
) (
    input  logic               clk,
    input  logic               rst,
    video_pattern_gen_if.master vid
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned H_START = H_SYNC + H_BP;
    localparam int unsigned H_END   = H_START + H_ACTIVE;
    localparam int unsigned V_START = V_SYNC + V_BP;
    localparam int unsigned V_END   = V_START + V_ACTIVE;
    localparam int unsigned BAR_W   = H_ACTIVE / 8;

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [2:0]       bar_idx_q, bar_idx_d;
    logic [CNT_W-1:0] bar_rem_q, bar_rem_d;
    logic [CNT_W-1:0] gx_q, gx_d;
    logic [CNT_W-1:0] gy_q, gy_d;

    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             de_q, de_d;
    logic             de_read_q, de_read_d;
    logic             fs_q, fs_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic [23:0]      rgb_q, rgb_d;

    logic             h_act, v_act, pre_act, h_wrap, v_wrap, origin, grid_on;
    logic [CNT_W:0]   h_pre;
    logic [CNT_W-1:0] x_pos, y_pos;
    logic [23:0]      pix;

    // Colour-bar palette: white, yellow, cyan, green, magenta, red, blue, black
    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = 24'hffffff;
            3'd1:    bar_color = 24'hffff00;
            3'd2:    bar_color = 24'h00ffff;
            3'd3:    bar_color = 24'h00ff00;
            3'd4:    bar_color = 24'hff00ff;
            3'd5:    bar_color = 24'hff0000;
            3'd6:    bar_color = 24'h0000ff;
            default: bar_color = 24'h000000;
        endcase
    endfunction

    // Timing decode, pattern counters and next-state of every register
    always_comb begin
        h_act   = (h_cnt_q >= CNT_W'(H_START)) && (h_cnt_q < CNT_W'(H_END));
        v_act   = (v_cnt_q >= CNT_W'(V_START)) && (v_cnt_q < CNT_W'(V_END));
        // Wider add so a lookahead past the line end never aliases into the window
        h_pre   = {1'b0, h_cnt_q} + (CNT_W+1)'(PREFETCH);
        pre_act = (h_pre >= (CNT_W+1)'(H_START)) && (h_pre < (CNT_W+1)'(H_END));
        h_wrap  = (h_cnt_q == CNT_W'(H_TOTAL - 1));
        v_wrap  = (v_cnt_q == CNT_W'(V_TOTAL - 1));
        origin  = (h_cnt_q == '0) && (v_cnt_q == '0);
        x_pos   = h_cnt_q - CNT_W'(H_START);
        y_pos   = v_cnt_q - CNT_W'(V_START);

        h_cnt_d = h_wrap ? '0 : h_cnt_q + CNT_W'(1);
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + CNT_W'(1);
        end

        mode_d = origin ? vid.mode : mode_q;

        // Bar tracker: preloaded during blanking, steps every BAR_W pixels,
        // sticks at bar 7 so the last bar absorbs the remainder.
        bar_idx_d = 3'd0;
        bar_rem_d = CNT_W'(BAR_W - 1);
        if (h_act) begin
            bar_idx_d = bar_idx_q;
            bar_rem_d = bar_rem_q;
            if (bar_rem_q != '0) begin
                bar_rem_d = bar_rem_q - CNT_W'(1);
            end else if (bar_idx_q != 3'd7) begin
                bar_idx_d = bar_idx_q + 3'd1;
                bar_rem_d = CNT_W'(BAR_W - 1);
            end
        end

        // Grid modulo counters: x cleared outside the active span of a line,
        // y cleared on every vertical-blanking line (which covers frame start).
        gx_d = '0;
        if (h_act) begin
            gx_d = (gx_q == CNT_W'(GRID_STEP - 1)) ? '0 : gx_q + CNT_W'(1);
        end
        gy_d = gy_q;
        if (h_wrap) begin
            gy_d = '0;
            if (v_act) begin
                gy_d = (gy_q == CNT_W'(GRID_STEP - 1)) ? '0 : gy_q + CNT_W'(1);
            end
        end

        grid_on = (gx_q == '0) || (gy_q == '0) ||
                  (h_cnt_q == CNT_W'(H_END - 1)) || (v_cnt_q == CNT_W'(V_END - 1));

        case (mode_q)
            2'd0:    pix = bar_color(bar_idx_q);
            2'd1:    pix = {3{x_pos[7:0]}};
            2'd2:    pix = grid_on ? 24'hffffff : 24'h000000;
            default: pix = vid.solid_rgb;
        endcase

        hs_d      = (h_cnt_q < CNT_W'(H_SYNC)) ? HS_POL : ~HS_POL;
        vs_d      = (v_cnt_q < CNT_W'(V_SYNC)) ? VS_POL : ~VS_POL;
        de_d      = h_act && v_act;
        de_read_d = pre_act && v_act;
        fs_d      = origin;
        x_d       = de_d ? x_pos : '0;
        y_d       = de_d ? y_pos : '0;
        rgb_d     = de_d ? pix : 24'h000000;
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            mode_q    <= 2'd0;
            bar_idx_q <= 3'd0;
            bar_rem_q <= CNT_W'(BAR_W - 1);
            gx_q      <= '0;
            gy_q      <= '0;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            de_q      <= 1'b0;
            de_read_q <= 1'b0;
            fs_q      <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            rgb_q     <= 24'h000000;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            mode_q    <= mode_d;
            bar_idx_q <= bar_idx_d;
            bar_rem_q <= bar_rem_d;
            gx_q      <= gx_d;
            gy_q      <= gy_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            de_q      <= de_d;
            de_read_q <= de_read_d;
            fs_q      <= fs_d;
            x_q       <= x_d;
            y_q       <= y_d;
            rgb_q     <= rgb_d;
        end
    end

    assign vid.hs          = hs_q;
    assign vid.vs          = vs_q;
    assign vid.de          = de_q;
    assign vid.de_read     = de_read_q;
    assign vid.frame_start = fs_q;
    assign vid.active_x    = x_q;
    assign vid.active_y    = y_q;
    assign vid.rgb_r       = rgb_q[23:16];
    assign vid.rgb_g       = rgb_q[15:8];
    assign vid.rgb_b       = rgb_q[7:0];

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench for video_pattern_gen on a 25x8 small raster.
module tb_video_pattern_gen;

    localparam int HA = 16, HF = 2, HSY = 3, HB = 4;
    localparam int VA = 4,  VF = 1, VSY = 1, VB = 2;
    localparam int HT = HA + HF + HSY + HB;   // 25
    localparam int VT = VA + VF + VSY + VB;   // 8
    localparam int FT = HT * VT;              // 200
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    video_pattern_gen_if #(.CNT_W(CW)) vif ();

    video_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(CW),
        .PREFETCH(3), .GRID_STEP(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vid(vif.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [23:0] bars [8] = '{24'hffffff, 24'hffff00, 24'h00ffff, 24'h00ff00,
                              24'hff00ff, 24'hff0000, 24'h0000ff, 24'h000000};

    // Reference: position in the frame the current outputs describe, the mode
    // that frame was latched with, and the solid colour seen at the last edge.
    int          m_next  = 0;
    int          m_cur   = 0;
    bit          m_valid = 1'b0;
    logic [1:0]  m_mode  = 2'd0;
    logic [1:0]  m_used  = 2'd0;
    logic [23:0] m_sol   = 24'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_next  <= 0;
            m_valid <= 1'b0;
            m_mode  <= 2'd0;
        end else begin
            m_valid <= 1'b1;
            m_cur   <= m_next;
            m_used  <= m_mode;
            m_sol   <= vif.solid_rgb;
            if (m_next == 0) m_mode <= vif.mode;
            m_next  <= (m_next + 1) % FT;
        end
    end

    // Event counters and rise trackers, maintained by the compare process
    int cnt_hs = 0, cnt_vs = 0, cnt_de = 0, cnt_dr = 0, cnt_fs = 0;
    int cyc = 0, last_fs = -1, last_dr_rise = -1;
    bit prev_de = 1'b0, prev_dr = 1'b0;

    always @(negedge clk) begin : cmp
        int h, v, x, y, b;
        bit e_de, e_dr;
        logic [23:0] e_rgb;
        cyc++;
        if (rst || !m_valid) begin
            chk("rst_hs", 32'(vif.hs), 32'd0);
            chk("rst_vs", 32'(vif.vs), 32'd0);
            chk("rst_de", 32'(vif.de), 32'd0);
            chk("rst_de_read", 32'(vif.de_read), 32'd0);
            chk("rst_fs", 32'(vif.frame_start), 32'd0);
            chk("rst_x", 32'(vif.active_x), 32'd0);
            chk("rst_y", 32'(vif.active_y), 32'd0);
            chk("rst_rgb", 32'({vif.rgb_r, vif.rgb_g, vif.rgb_b}), 32'd0);
            last_fs = -1; last_dr_rise = -1; prev_de = 1'b0; prev_dr = 1'b0;
        end else begin
            h = m_cur % HT;
            v = m_cur / HT;
            x = h - (HSY + HB);
            y = v - (VSY + VB);
            e_de = (x >= 0) && (x < HA) && (y >= 0) && (y < VA);
            e_dr = (x + 3 >= 0) && (x + 3 < HA) && (y >= 0) && (y < VA);
            e_rgb = 24'h0;
            if (e_de) begin
                case (m_used)
                    2'd0: begin b = x / (HA / 8); if (b > 7) b = 7; e_rgb = bars[b]; end
                    2'd1: e_rgb = {3{8'(x % 256)}};
                    2'd2: e_rgb = ((x % 4 == 0) || (y % 4 == 0) || (x == HA-1) || (y == VA-1))
                                  ? 24'hffffff : 24'h0;
                    default: e_rgb = m_sol;
                endcase
            end
            chk("hs", 32'(vif.hs), 32'(h < HSY));
            chk("vs", 32'(vif.vs), 32'(v < VSY));
            chk("de", 32'(vif.de), 32'(e_de));
            chk("de_read", 32'(vif.de_read), 32'(e_dr));
            chk("frame_start", 32'(vif.frame_start), 32'(m_cur == 0));
            chk("rgb", 32'({vif.rgb_r, vif.rgb_g, vif.rgb_b}), 32'(e_rgb));
            if (e_de) begin
                chk("x", 32'(vif.active_x), 32'(x));
                chk("y", 32'(vif.active_y), 32'(y));
            end
            if (vif.frame_start) begin
                if (last_fs >= 0) chk("fs_period", 32'(cyc - last_fs), 32'(FT));
                last_fs = cyc;
            end
            if (vif.de_read && !prev_dr) last_dr_rise = cyc;
            if (vif.de && !prev_de) chk("de_read_lead", 32'(cyc - last_dr_rise), 32'd3);
            prev_de = vif.de;
            prev_dr = vif.de_read;
            cnt_hs += int'(vif.hs);
            cnt_vs += int'(vif.vs);
            cnt_de += int'(vif.de);
            cnt_dr += int'(vif.de_read);
            cnt_fs += int'(vif.frame_start);
        end
    end

    task automatic wait_frame();
        int n = 0;
        do begin @(negedge clk); n++; end while (!vif.frame_start && n < 2 * FT);
        if (!vif.frame_start) chk("wait_frame_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_pix(input int px, input int py);
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!(vif.de && int'(vif.active_x) == px && int'(vif.active_y) == py) && n < 2 * FT);
        if (!(vif.de && int'(vif.active_x) == px && int'(vif.active_y) == py))
            chk("wait_pix_timeout", 32'd0, 32'd1);
    endtask

    task automatic pin_pix(input string name, input int px, input int py, input logic [23:0] exp);
        wait_pix(px, py);
        chk(name, 32'({vif.rgb_r, vif.rgb_g, vif.rgb_b}), 32'(exp));
    endtask

    task automatic count_window(input int cycles, input int e_hs, input int e_vs,
                                input int e_de, input int e_fs);
        int s_hs, s_vs, s_de, s_dr, s_fs;
        s_hs = cnt_hs; s_vs = cnt_vs; s_de = cnt_de; s_dr = cnt_dr; s_fs = cnt_fs;
        repeat (cycles) @(negedge clk);
        #1;
        chk("cnt_hs", 32'(cnt_hs - s_hs), 32'(e_hs));
        chk("cnt_vs", 32'(cnt_vs - s_vs), 32'(e_vs));
        chk("cnt_de", 32'(cnt_de - s_de), 32'(e_de));
        chk("cnt_de_read", 32'(cnt_dr - s_dr), 32'(e_de));
        chk("cnt_fs", 32'(cnt_fs - s_fs), 32'(e_fs));
    endtask

    initial begin
        vif.mode      = 2'd0;
        vif.solid_rgb = 24'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;

        // Free run, three frames: 3 hs per line, 25 vs cycles, 64 de cycles per frame
        count_window(3 * FT, 3 * 3 * VT, 3 * HT, 3 * 64, 3);

        // Colour bars, two pixels per bar
        pin_pix("bar_x0", 0, 0, 24'hffffff);
        pin_pix("bar_x1", 1, 0, 24'hffffff);
        pin_pix("bar_x2", 2, 0, 24'hffff00);
        pin_pix("bar_x3", 3, 0, 24'hffff00);
        pin_pix("bar_x14", 14, 0, 24'h000000);

        // Mid-frame switch to solid: current frame keeps bars, next is solid
        wait_pix(0, 1);
        vif.mode      = 2'd3;
        vif.solid_rgb = 24'h123456;
        pin_pix("mid_switch_bar", 5, 2, 24'h00ffff);
        wait_frame();
        pin_pix("solid_first", 0, 0, 24'h123456);
        pin_pix("solid_last", 15, 3, 24'h123456);

        // Grid pattern
        vif.mode = 2'd2;
        wait_frame();
        pin_pix("grid_0_0", 0, 0, 24'hffffff);
        pin_pix("grid_1_1", 1, 1, 24'h000000);
        pin_pix("grid_4_1", 4, 1, 24'hffffff);
        pin_pix("grid_6_2", 6, 2, 24'h000000);
        pin_pix("grid_15_2", 15, 2, 24'hffffff);
        pin_pix("grid_5_3", 5, 3, 24'hffffff);

        // Gray ramp pinned once
        vif.mode = 2'd1;
        wait_frame();
        pin_pix("ramp_9_0", 9, 0, 24'h090909);

        // Randomised mode and colour changes, checked by the reference every cycle
        for (int i = 0; i < 6 * FT; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 59) == 0) vif.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) vif.solid_rgb = 24'($urandom);
        end

        // Asynchronous reset in the middle of an active line
        vif.mode = 2'd3;
        vif.solid_rgb = 24'hffffff;
        wait_frame();
        wait_pix(8, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_de", 32'(vif.de), 32'd0);
        chk("async_de_read", 32'(vif.de_read), 32'd0);
        chk("async_rgb", 32'({vif.rgb_r, vif.rgb_g, vif.rgb_b}), 32'd0);
        chk("async_hs", 32'(vif.hs), 32'd0);
        chk("async_vs", 32'(vif.vs), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        begin
            int s_fs;
            s_fs = cnt_fs;
            @(posedge clk);
            #1;
            chk("post_rst_fs", 32'(vif.frame_start), 32'd1);
            chk("post_rst_hs", 32'(vif.hs), 32'd1);
            repeat (FT - 1) @(negedge clk);
            #1;
            chk("post_rst_fs_count", 32'(cnt_fs - s_fs), 32'd1);
        end
        count_window(FT, 3 * VT, HT, 64, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    // Absolute guard so the run always ends
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
